// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the sequencer state encoding.
// Imported by the divider sequencer and its divider core.
package fp32_pkg;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_ONE  = 32'h3F800000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CLR  = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;
endpackage

// File: rtl/divide_f32.sv
// Iterative FP32 divider: one quotient bit per cycle, round to nearest.
// Restarts on rst; rdy stays high with quo until the next rst.
module divide_f32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic        rdy,
  output logic [31:0] quo
);
  logic               started;
  logic               busy;
  logic [4:0]         step;
  logic [24:0]        rem;
  logic [23:0]        dm;
  logic [25:0]        q;
  logic               sgn;
  logic signed [9:0]  ex;

  logic a_z, b_z, a_i, b_i, a_n, b_n, s_in;
  logic        spec;
  logic [31:0] sq;
  logic [23:0] mant;
  logic        g, st;
  logic signed [9:0] e;
  logic [24:0] rnd;
  logic [31:0] res;

  assign a_z  = num[30:23] == 8'h00;
  assign b_z  = den[30:23] == 8'h00;
  assign a_i  = (&num[30:23]) && !(|num[22:0]);
  assign b_i  = (&den[30:23]) && !(|den[22:0]);
  assign a_n  = (&num[30:23]) && (|num[22:0]);
  assign b_n  = (&den[30:23]) && (|den[22:0]);
  assign s_in = num[31] ^ den[31];

  // special operands resolve without iterating
  always_comb begin
    spec = 1'b1;
    sq   = 32'h0;
    if (a_n || b_n || (a_z && b_z) || (a_i && b_i))
      sq = FP32_QNAN;
    else if (a_i || b_z)
      sq = {s_in, FP32_PINF[30:0]};
    else if (a_z || b_i)
      sq = {s_in, 31'h0};
    else
      spec = 1'b0;
  end

  // normalise, round to nearest even, range check
  always_comb begin
    e    = ex;
    mant = q[25:2];
    g    = q[1];
    st   = q[0] | (|rem);
    if (!q[25]) begin
      mant = q[24:1];
      g    = q[0];
      st   = |rem;
      e    = ex - 10'sd1;
    end
    rnd = {1'b0, mant} + {24'h0, g & (st | mant[0])};
    if (rnd[24]) e = e + 10'sd1;
    if (e > 10'sd254)
      res = {sgn, FP32_PINF[30:0]};
    else if (e < 10'sd1)
      res = {sgn, 31'h0};
    else
      res = {sgn, e[7:0], rnd[22:0]};
  end

  // setup, restoring mantissa division, final result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      started <= 1'b0;
      busy    <= 1'b0;
      rdy     <= 1'b0;
      quo     <= 32'h0;
      step    <= 5'd0;
      rem     <= 25'h0;
      dm      <= 24'h0;
      q       <= 26'h0;
      sgn     <= 1'b0;
      ex      <= 10'sd0;
    end else if (!started) begin
      started <= 1'b1;
      sgn     <= s_in;
      ex      <= $signed({2'b00, num[30:23]})
               - $signed({2'b00, den[30:23]}) + 10'sd127;
      rem     <= {2'b01, num[22:0]};
      dm      <= {1'b1, den[22:0]};
      q       <= 26'h0;
      step    <= 5'd0;
      if (spec) begin
        rdy <= 1'b1;
        quo <= sq;
      end else begin
        busy <= 1'b1;
      end
    end else if (busy) begin
      if (step == 5'd26) begin
        busy <= 1'b0;
        rdy  <= 1'b1;
        quo  <= res;
      end else begin
        if (rem >= {1'b0, dm}) begin
          rem <= (rem - {1'b0, dm}) << 1;
          q   <= {q[24:0], 1'b1};
        end else begin
          rem <= rem << 1;
          q   <= {q[24:0], 1'b0};
        end
        step <= step + 5'd1;
      end
    end
  end
endmodule

// File: rtl/divide_f32_seq.sv
// Issue/collect sequencer around divide_f32, one op in flight.
// DIV_TIMEOUT_EN: bound RUN to MAX_CYCLES and return qNaN with out_err.
module divide_f32_seq
  import fp32_pkg::*;
#(
  parameter int MAX_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_num,
  input  logic [31:0]      in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quo,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] out_cycles,
  output logic             out_err
);
`ifdef DIV_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_CYCLES - 1);

  state_t           state;
  logic [31:0]      num_q, den_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;
  logic             div_rst, div_rdy, tmo;
  logic [31:0]      div_quo;

  assign div_rst  = rst | (state == CLR);
  assign in_ready = !rst && (state == IDLE);
  assign tmo      = TMO_EN && (cnt == LIM) && !div_rdy;

  divide_f32 u_div (
    .clk (clk),
    .rst (div_rst),
    .num (num_q),
    .den (den_q),
    .rdy (div_rdy),
    .quo (div_quo)
  );

  // issue/run/collect FSM with cycle counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_quo    <= 32'h0;
      out_tag    <= '0;
      out_cycles <= '0;
      out_err    <= 1'b0;
      num_q      <= 32'h0;
      den_q      <= 32'h0;
      tag_q      <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          num_q <= in_num;
          den_q <= in_den;
          tag_q <= in_tag;
          state <= CLR;
        end
        CLR: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (div_rdy) begin
            out_quo    <= div_quo;
            out_cycles <= cnt;
            out_tag    <= tag_q;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (tmo) begin
            out_quo    <= FP32_QNAN;
            out_err    <= 1'b1;
            out_cycles <= LIM;
            out_tag    <= tag_q;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divide_f32_seq.sv
// Randomised self-checking bench for divide_f32_seq.
// Reference quotient comes from real arithmetic on the decoded operands.
module tb_divide_f32_seq;
`ifdef DIV_TIMEOUT_EN
  localparam int MAXC = 2;
  localparam bit TMO  = 1'b1;
`else
  localparam int MAXC = 32;
  localparam bit TMO  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_num, in_den;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_quo;
  logic [3:0]  out_tag;
  logic [5:0]  out_cycles;
  logic        out_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  divide_f32_seq #(.MAX_CYCLES(MAXC), .CNT_W(6), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_den     (in_den),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quo    (out_quo),
    .out_tag    (out_tag),
    .out_cycles (out_cycles),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && in_valid && in_ready) n_acc <= n_acc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp, input int unsigned tol = 0);
    logic [31:0] d;
    n_tests++;
    d = (got > exp) ? got - exp : exp - got;
    if ((^got === 1'bx) || (d > tol)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    e = 11'({3'b000, f[30:23]}) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [22:0] f;
    logic [28:0] rest;
    logic [23:0] m;
    d    = $realtobits(r);
    e    = int'(d[62:52]) - 896;
    f    = d[51:29];
    rest = d[28:0];
    m    = {1'b0, f};
    if (rest > 29'h10000000 || (rest == 29'h10000000 && f[0])) m = m + 24'd1;
    if (m[23]) e++;
    if (e >= 255) return {d[63], 31'h7F800000};
    if (e <= 0) return {d[63], 31'h0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  typedef struct packed {
    logic [31:0] quo;
    logic        err;
    logic        tol;
  } exp_t;

  function automatic bit fz(input logic [31:0] f);
    return f[30:23] == 8'h00;
  endfunction
  function automatic bit fi(input logic [31:0] f);
    return f[30:23] == 8'hFF && f[22:0] == 0;
  endfunction
  function automatic bit fn(input logic [31:0] f);
    return f[30:23] == 8'hFF && f[22:0] != 0;
  endfunction

  function automatic exp_t expect_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic s;
    s     = a[31] ^ b[31];
    e.err = 1'b0;
    e.tol = 1'b0;
    if (fn(a) || fn(b) || (fz(a) && fz(b)) || (fi(a) && fi(b)))
      e.quo = 32'h7FC00000;
    else if (fi(a) || fz(b))
      e.quo = {s, 31'h7F800000};
    else if (fz(a) || fi(b))
      e.quo = {s, 31'h0};
    else if (TMO) begin
      e.quo = 32'h7FC00000;
      e.err = 1'b1;
    end else begin
      e.quo = r2f(f2r(a) / f2r(b));
      e.tol = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_norm();
    logic [31:0] v;
    v = $urandom;
    return {v[31], 8'($urandom_range(110, 144)), v[22:0]};
  endfunction

  task automatic run_op(input string nm, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tg,
                        input int hold);
    exp_t        e;
    int          w;
    int          lat;
    logic [31:0] q0;
    logic [5:0]  c0;
    e        = expect_op(a, b);
    in_num   = a;
    in_den   = b;
    in_tag   = tg;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_accept"}, 32'(w < 50), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_num   = $urandom;
    in_den   = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_quo"}, out_quo, e.quo, e.tol ? 1 : 0);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tg));
    chk({nm, "_err"}, 32'(out_err), 32'(e.err));
    chk({nm, "_cycles"}, 32'(out_cycles), 32'(lat - 3));
    if (e.err) chk({nm, "_tmo_cycles"}, 32'(out_cycles), 32'(MAXC - 1));
    q0 = out_quo;
    c0 = out_cycles;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_quo"}, out_quo, q0);
      chk({nm, "_hold_tag"}, 32'(out_tag), 32'(tg));
      chk({nm, "_hold_cyc"}, 32'(out_cycles), 32'(c0));
      chk({nm, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle"}, 32'(in_ready), 32'd1);
    chk({nm, "_drop_err"}, 32'(out_err), 32'd0);
  endtask

  logic [31:0] bn[3];
  logic [31:0] bd[3];
  int          acc0;
  int          bad;
  int          w0;

  initial begin
    bn = '{32'h40E00000, 32'hC1100000, 32'h3F800000};
    bd = '{32'h40000000, 32'h40800000, 32'h40400000};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_num    = 32'h0;
    in_den    = 32'h0;
    in_tag    = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_quo", out_quo, 32'h0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_cycles", 32'(out_cycles), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run_op("basic", 32'h40C00000, 32'h40400000, 4'd3, 0);
    run_op("divzero", 32'h3F800000, 32'h00000000, 4'd5, 0);
    chk("divzero_fast", 32'(out_cycles <= 6'd2), 32'd1);
    run_op("bp", 32'h41200000, 32'hC0800000, 4'd9, 5);
    run_op("tmo", 32'h40A00000, 32'h40E00000, 4'd6, 0);

    acc0      = n_acc;
    out_ready = 1'b1;
    fork
      begin
        int w;
        for (int i = 0; i < 3; i++) begin
          in_num   = bn[i];
          in_den   = bd[i];
          in_tag   = 4'(i + 1);
          in_valid = 1'b1;
          w = 0;
          while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int   w;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
          e = expect_op(bn[i], bd[i]);
          w = 0;
          while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
          end
          chk("b2b_valid", 32'(out_valid), 32'd1);
          chk("b2b_tag", 32'(out_tag), 32'(i + 1));
          chk("b2b_quo", out_quo, e.quo, e.tol ? 1 : 0);
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_accepts", 32'(n_acc - acc0), 32'd3);
    chk("b2b_no_extra", 32'(out_valid), 32'd0);

    in_num   = 32'h40400000;
    in_den   = 32'h3F800000;
    in_tag   = 4'd7;
    in_valid = 1'b1;
    w0 = 0;
    while (!in_ready && w0 < 50) begin
      @(negedge clk);
      w0++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);
    run_op("after_rst", 32'h40E00000, 32'h40000000, 4'd8, 1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      int          k;
      k = $urandom_range(0, 5);
      a = rand_norm();
      b = rand_norm();
      if (k == 0) b = {b[31], 31'h0};
      if (k == 1) a = {a[31], 31'h0};
      run_op("rand", a, b, 4'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
